// File: rtl/wb_stage.sv
// Writeback stage: picks the destination value by rd_sel, waits for and
// extends load data, drives the register-file write port and counts
// retired instructions.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   in_valid/in_ready          upstream handshake
//   rd_sel, reg_write, rd_addr decoded writeback controls
//   funct3                     load width/sign
//   alu_result, imm, pc        candidate writeback sources (alu_result is the load address)
//   mem_rvalid, mem_rdata      load data return
//   rf_we, rf_waddr, rf_wdata  register-file write port (registered)
//   mem_err                    one-cycle pulse on load timeout
//   instret                    retired-instruction counter
module wb_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       rd_sel,
  input  logic             reg_write,
  input  logic [4:0]       rd_addr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   wait_cnt, cnt_n, cnt_inc;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic            ld_latch;
  logic            we_n, err_n, inc_n;
  logic [4:0]      waddr_n;
  logic [XLEN-1:0] wdata_n, sel_data, load_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            xfer, no_write;

  assign in_ready = (state == IDLE) || (state == WRITE);
  assign xfer     = in_valid && in_ready;
  assign no_write = !reg_write || (rd_addr == 5'd0);
  assign cnt_inc  = wait_cnt + CW'(1);

  // Non-load writeback source
  always_comb begin
    case (rd_sel)
      2'b01:   sel_data = imm;
      2'b10:   sel_data = alu_result;
      default: sel_data = pc + XLEN'(4);
    endcase
  end

  // Lane extraction and extension of the returned load word
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_f3)
      3'b000:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ld_rd    <= '0;
      ld_f3    <= '0;
      ld_off   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mem_err  <= 1'b0;
      instret  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= cnt_n;
      rf_we    <= we_n;
      rf_waddr <= waddr_n;
      rf_wdata <= wdata_n;
      mem_err  <= err_n;
      if (inc_n) instret <= instret + CNT_W'(1);
      if (ld_latch) begin
        ld_rd  <= rd_addr;
        ld_f3  <= funct3;
        ld_off <= alu_result[1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE, WRITE: begin
        if (!xfer)               state_n = IDLE;
        else if (no_write)       state_n = IDLE;
        else if (rd_sel == 2'b00) state_n = WAIT_MEM;
        else                     state_n = WRITE;
      end
      WAIT_MEM: begin
        if (mem_rvalid)                    state_n = WRITE;
        else if (cnt_inc == CW'(MEM_TIMEOUT)) state_n = IDLE;
        else                               state_n = WAIT_MEM;
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; write data is captured on entry to WRITE
  always_comb begin
    we_n     = 1'b0;
    err_n    = 1'b0;
    inc_n    = 1'b0;
    waddr_n  = rf_waddr;
    wdata_n  = rf_wdata;
    cnt_n    = wait_cnt;
    ld_latch = 1'b0;
    case (state)
      IDLE, WRITE: begin
        if (xfer) begin
          if (no_write) begin
            inc_n = 1'b1;
          end else if (rd_sel == 2'b00) begin
            ld_latch = 1'b1;
            cnt_n    = '0;
          end else begin
            we_n    = 1'b1;
            inc_n   = 1'b1;
            waddr_n = rd_addr;
            wdata_n = sel_data;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          we_n    = 1'b1;
          inc_n   = 1'b1;
          waddr_n = ld_rd;
          wdata_n = load_ext;
        end else if (cnt_inc == CW'(MEM_TIMEOUT)) begin
          err_n = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  rd_sel;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [31:0] alu_result, imm, pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_err;
  logic [31:0] instret;

  int tests = 0;
  int fails = 0;
  logic seen_bad;

  wb_stage #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rd_sel(rd_sel), .reg_write(reg_write), .rd_addr(rd_addr), .funct3(funct3),
    .alu_result(alu_result), .imm(imm), .pc(pc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_err(mem_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu);
    in_valid   = 1'b1;
    reg_write  = 1'b1;
    rd_sel     = sel;
    rd_addr    = rd;
    funct3     = f3;
    alu_result = alu;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; rd_sel = 2'b00; reg_write = 1'b0; rd_addr = 5'd0;
    funct3 = 3'b000; alu_result = '0; imm = '0; pc = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_err", 64'(mem_err), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // ALU op
    issue(2'b10, 5'd5, 3'b000, 32'h0000_1234);
    tick();
    in_valid = 1'b0;
    check("alu_we", 64'(rf_we), 64'd1);
    check("alu_waddr", 64'(rf_waddr), 64'd5);
    check("alu_wdata", 64'(rf_wdata), 64'h1234);
    check("alu_instret", 64'(instret), 64'd1);
    tick();
    check("alu_we_drop", 64'(rf_we), 64'd0);
    check("alu_hold", 64'(rf_wdata), 64'h1234);

    // JAL then LUI back-to-back
    issue(2'b11, 5'd1, 3'b000, 32'h0);
    pc = 32'hFFFF_FFFC;
    tick();
    check("jal_we", 64'(rf_we), 64'd1);
    check("jal_waddr", 64'(rf_waddr), 64'd1);
    check("jal_wdata", 64'(rf_wdata), 64'h0);
    check("jal_ready", 64'(in_ready), 64'd1);
    issue(2'b01, 5'd2, 3'b000, 32'h0);
    imm = 32'hABCD_E000;
    tick();
    in_valid = 1'b0;
    check("lui_we", 64'(rf_we), 64'd1);
    check("lui_waddr", 64'(rf_waddr), 64'd2);
    check("lui_wdata", 64'(rf_wdata), 64'hABCD_E000);
    check("lui_instret", 64'(instret), 64'd3);
    tick();
    check("lui_we_drop", 64'(rf_we), 64'd0);

    // mem_rvalid outside WAIT_MEM is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    check("stray_rvalid_we", 64'(rf_we), 64'd0);

    // LB offset 3
    issue(2'b00, 5'd7, 3'b000, 32'h0000_0103);
    tick();
    in_valid = 1'b0;
    check("lb_ready_wait", 64'(in_ready), 64'd0);
    check("lb_we_wait", 64'(rf_we), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    check("lb_ready_still", 64'(in_ready), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0;
    check("lb_we", 64'(rf_we), 64'd1);
    check("lb_waddr", 64'(rf_waddr), 64'd7);
    check("lb_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
    check("lb_instret", 64'(instret), 64'd4);

    // LHU offset 2
    issue(2'b00, 5'd8, 3'b101, 32'h0000_0202);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0;
    check("lhu_we", 64'(rf_we), 64'd1);
    check("lhu_wdata", 64'(rf_wdata), 64'h0000_80FF);
    check("lhu_instret", 64'(instret), 64'd5);

    // LH offset 0 sign-extends the low half
    issue(2'b00, 5'd12, 3'b001, 32'h0000_0300);
    tick();
    in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_9ABC;
    tick();
    mem_rvalid = 1'b0;
    check("lh_wdata", 64'(rf_wdata), 64'hFFFF_9ABC);
    check("lh_instret", 64'(instret), 64'd6);

    // Timeout: no mem_rvalid for 16 wait cycles
    issue(2'b00, 5'd9, 3'b010, 32'h0000_0400);
    tick();
    in_valid = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_err || rf_we || in_ready) seen_bad = 1'b1;
    end
    check("to_early_activity", 64'(seen_bad), 64'd0);
    tick();
    check("to_err", 64'(mem_err), 64'd1);
    check("to_we", 64'(rf_we), 64'd0);
    check("to_instret", 64'(instret), 64'd6);
    check("to_ready", 64'(in_ready), 64'd1);
    tick();
    check("to_err_pulse", 64'(mem_err), 64'd0);

    // rvalid exactly on the limit cycle: data wins
    issue(2'b00, 5'd10, 3'b010, 32'h0000_0500);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("lim_we", 64'(rf_we), 64'd1);
    check("lim_err", 64'(mem_err), 64'd0);
    check("lim_waddr", 64'(rf_waddr), 64'd10);
    check("lim_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    check("lim_instret", 64'(instret), 64'd7);

    // rd=0 and reg_write=0 retire without writing
    issue(2'b10, 5'd0, 3'b000, 32'h0000_0077);
    tick();
    check("rd0_we", 64'(rf_we), 64'd0);
    check("rd0_instret", 64'(instret), 64'd8);
    issue(2'b10, 5'd3, 3'b000, 32'h0000_0088);
    reg_write = 1'b0;
    tick();
    in_valid = 1'b0;
    check("nowr_we", 64'(rf_we), 64'd0);
    check("nowr_instret", 64'(instret), 64'd9);
    check("nowr_hold_addr", 64'(rf_waddr), 64'd10);

    // Reset while waiting for load data
    issue(2'b00, 5'd11, 3'b010, 32'h0000_0600);
    tick();
    in_valid = 1'b0;
    tick();
    check("rstw_ready_wait", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    check("rstw_we", 64'(rf_we), 64'd0);
    check("rstw_waddr", 64'(rf_waddr), 64'd0);
    check("rstw_wdata", 64'(rf_wdata), 64'd0);
    check("rstw_instret", 64'(instret), 64'd0);
    check("rstw_err", 64'(mem_err), 64'd0);
    check("rstw_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
